// File: rtl/rv64g_reg_lock_tracker.sv
// -----------------------------------------------------------------------------
// rv64g_reg_lock_tracker
//
// Keeps the per-register lock vector that the instruction launcher consults
// before issuing. Each architectural register r >= 1 has a small saturating
// counter of outstanding writes: a launch that writes rd bumps cnt[rd], and the
// matching writeback drops it. A launched jump/branch locks the whole file
// until jump_done_i arrives. Register 0 (x0) never holds a counter lock.
//
// Optional feature (macro RV64G_LOCK_WATCHDOG_EN): per-register age counters
// flag any lock held for WD_CYCLES cycles via sticky wd_expired_o/wd_reg_o.
//
// Ports:
//   clk_i, arst_i       clock, asynchronous active-high reset
//   clear_i             synchronous flush of counters and jump lock
//   launch_valid_i/ready_i, launch_rd_i, launch_we_i, launch_jump_i
//                       observed launcher output handshake and its payload
//   jump_done_i         jump resolved pulse
//   wb_valid_i, wb_rd_i register-file writeback completion
//   locks_o             lock vector to launcher (registered state only)
//   busy_o              OR of locks_o
//   overflow_o          sticky: launch hit a saturated counter
//   underflow_o         sticky: writeback hit a zero counter
//   wd_expired_o, wd_reg_o   (watchdog build only) first expiry and its index
// -----------------------------------------------------------------------------
module rv64g_reg_lock_tracker #(
    parameter int NR    = 64,
    parameter int RW    = $clog2(NR),
    parameter int CNT_W = 2
`ifdef RV64G_LOCK_WATCHDOG_EN
    ,
    parameter int WD_CYCLES = 1024
`endif
) (
    input  logic          clk_i,
    input  logic          arst_i,
    input  logic          clear_i,
    input  logic          launch_valid_i,
    input  logic          launch_ready_i,
    input  logic [RW-1:0] launch_rd_i,
    input  logic          launch_we_i,
    input  logic          launch_jump_i,
    input  logic          jump_done_i,
    input  logic          wb_valid_i,
    input  logic [RW-1:0] wb_rd_i,
    output logic [NR-1:0] locks_o,
    output logic          busy_o,
    output logic          overflow_o,
    output logic          underflow_o
`ifdef RV64G_LOCK_WATCHDOG_EN
    ,
    output logic          wd_expired_o,
    output logic [RW-1:0] wd_reg_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Entry 0 is never written (rd 0 is filtered out below), so it stays at
    // its reset value of zero and is never decoded into locks_o.
    logic [CNT_W-1:0] cnt [NR];
    logic             jump_pend;

    logic launch_fire;
    logic inc_req;
    logic dec_req;
    logic same_reg;

    assign launch_fire = launch_valid_i & launch_ready_i;
    assign inc_req     = launch_fire & launch_we_i & (launch_rd_i != '0);
    assign dec_req     = wb_valid_i & (wb_rd_i != '0);
    // A launch and a writeback to the same register cancel: counter holds,
    // and neither the saturation nor the zero check applies.
    assign same_reg    = inc_req & dec_req & (launch_rd_i == wb_rd_i);

    // NOTE: state is updated with non-blocking assignments so every read in
    // this block sees the pre-edge value, independent of statement order.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            // NOTE: the counters are a flop array, not a RAM; every entry is
            // reset so an asserted reset drops all locks without a clock.
            for (int r = 0; r < NR; r++) begin
                cnt[r] <= '0;
            end
            jump_pend   <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (clear_i) begin
            // Flush wins over any same-cycle event; error flags are kept.
            for (int r = 0; r < NR; r++) begin
                cnt[r] <= '0;
            end
            jump_pend <= 1'b0;
        end else begin
            if (inc_req && !same_reg) begin
                if (cnt[launch_rd_i] == CNT_MAX) begin
                    overflow_o <= 1'b1;
                end else begin
                    cnt[launch_rd_i] <= cnt[launch_rd_i] + CNT_W'(1);
                end
            end
            if (dec_req && !same_reg) begin
                if (cnt[wb_rd_i] == '0) begin
                    underflow_o <= 1'b1;
                end else begin
                    cnt[wb_rd_i] <= cnt[wb_rd_i] - CNT_W'(1);
                end
            end
            // A new jump beats a same-cycle resolve of the previous one.
            if (launch_fire && launch_jump_i) begin
                jump_pend <= 1'b1;
            end else if (jump_done_i) begin
                jump_pend <= 1'b0;
            end
        end
    end

    // Pure decode of registered state: no input reaches locks_o directly.
    // NOTE: every output of this block gets a default first so no path can
    // leave a bit unassigned and infer a latch.
    always_comb begin
        locks_o    = '0;
        locks_o[0] = jump_pend;
        for (int r = 1; r < NR; r++) begin
            locks_o[r] = (cnt[r] != '0) | jump_pend;
        end
    end

    assign busy_o = |locks_o;

`ifdef RV64G_LOCK_WATCHDOG_EN
    localparam int AW = $clog2(WD_CYCLES + 1);
    localparam logic [AW-1:0] AGE_LIMIT = AW'(WD_CYCLES);

    logic [AW-1:0] age [NR];
    logic          wd_hit;
    logic [RW-1:0] wd_hit_reg;

    // Descending scan so the lowest expired index is the one that sticks.
    always_comb begin
        wd_hit     = 1'b0;
        wd_hit_reg = '0;
        for (int r = NR - 1; r >= 1; r--) begin
            if (age[r] == AGE_LIMIT) begin
                wd_hit     = 1'b1;
                wd_hit_reg = RW'(r);
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int r = 0; r < NR; r++) begin
                age[r] <= '0;
            end
            wd_expired_o <= 1'b0;
            wd_reg_o     <= '0;
        end else begin
            for (int r = 0; r < NR; r++) begin
                if (clear_i || cnt[r] == '0) begin
                    age[r] <= '0;
                end else if (age[r] != AGE_LIMIT) begin
                    age[r] <= age[r] + AW'(1);
                end
            end
            if (!wd_expired_o && wd_hit) begin
                wd_expired_o <= 1'b1;
                wd_reg_o     <= wd_hit_reg;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv64g_reg_lock_tracker.sv
// -----------------------------------------------------------------------------
// tb_rv64g_reg_lock_tracker
//
// Directed bench for rv64g_reg_lock_tracker (default build). A reference
// model holds integer outstanding-write counts, the jump lock and the sticky
// error flags; a compare process checks every DUT output against it on each
// falling edge, and literal expectations at key points pin the model.
// -----------------------------------------------------------------------------
module tb_rv64g_reg_lock_tracker;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        clear_i;
    logic        launch_valid_i;
    logic        launch_ready_i;
    logic [5:0]  launch_rd_i;
    logic        launch_we_i;
    logic        launch_jump_i;
    logic        jump_done_i;
    logic        wb_valid_i;
    logic [5:0]  wb_rd_i;
    logic [63:0] locks_o;
    logic        busy_o;
    logic        overflow_o;
    logic        underflow_o;

    rv64g_reg_lock_tracker dut (
        .clk_i          (clk_i),
        .arst_i         (arst_i),
        .clear_i        (clear_i),
        .launch_valid_i (launch_valid_i),
        .launch_ready_i (launch_ready_i),
        .launch_rd_i    (launch_rd_i),
        .launch_we_i    (launch_we_i),
        .launch_jump_i  (launch_jump_i),
        .jump_done_i    (jump_done_i),
        .wb_valid_i     (wb_valid_i),
        .wb_rd_i        (wb_rd_i),
        .locks_o        (locks_o),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: outstanding writes per register as plain integers.
    int m_cnt [64];
    bit m_jp;
    bit m_ovf;
    bit m_unf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_jp  = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Apply the block's rules to the inputs present at this clock edge.
    task automatic model_edge();
        bit fire, inc, dec;
        int lr, wr;
        if (arst_i) begin
            model_reset();
            return;
        end
        if (clear_i) begin
            foreach (m_cnt[r]) m_cnt[r] = 0;
            m_jp = 1'b0;
            return;
        end
        fire = launch_valid_i && launch_ready_i;
        lr   = int'(launch_rd_i);
        wr   = int'(wb_rd_i);
        inc  = fire && launch_we_i && lr != 0;
        dec  = wb_valid_i && wr != 0;
        if (!(inc && dec && lr == wr)) begin
            if (inc) begin
                if (m_cnt[lr] >= 3) m_ovf = 1'b1;
                else m_cnt[lr] = m_cnt[lr] + 1;
            end
            if (dec) begin
                if (m_cnt[wr] <= 0) m_unf = 1'b1;
                else m_cnt[wr] = m_cnt[wr] - 1;
            end
        end
        if (fire && launch_jump_i) m_jp = 1'b1;
        else if (jump_done_i) m_jp = 1'b0;
    endtask

    function automatic logic [63:0] exp_locks();
        logic [63:0] v;
        v = '0;
        for (int r = 1; r < 64; r++) begin
            if (m_cnt[r] > 0) v[r] = 1'b1;
        end
        if (m_jp) v = '1;
        return v;
    endfunction

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("locks", locks_o, exp_locks());
            check("busy", 64'(busy_o), 64'(|exp_locks()));
            check("overflow", 64'(overflow_o), 64'(m_ovf));
            check("underflow", 64'(underflow_o), 64'(m_unf));
        end
    end

    // One clock: the model sees the same inputs the DUT sees at the edge.
    task automatic cycle();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic idle();
        clear_i        = 1'b0;
        launch_valid_i = 1'b0;
        launch_ready_i = 1'b0;
        launch_rd_i    = '0;
        launch_we_i    = 1'b0;
        launch_jump_i  = 1'b0;
        jump_done_i    = 1'b0;
        wb_valid_i     = 1'b0;
        wb_rd_i        = '0;
    endtask

    task automatic launch(input logic [5:0] rd, input logic we, input logic jmp);
        launch_valid_i = 1'b1;
        launch_ready_i = 1'b1;
        launch_rd_i    = rd;
        launch_we_i    = we;
        launch_jump_i  = jmp;
    endtask

    task automatic wb(input logic [5:0] rd);
        wb_valid_i = 1'b1;
        wb_rd_i    = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        idle();
        arst_i = 1'b1;
        model_reset();
        cycle();
        cycle();
        check("reset_locks", locks_o, 64'h0);
        check("reset_busy", 64'(busy_o), 64'h0);
        check("reset_flags", {62'h0, overflow_o, underflow_o}, 64'h0);
        arst_i = 1'b0;
        chk_en = 1'b1;
        cycle();

        // Launch rd 5, writeback at the third edge after: locked cycles 1..3.
        launch(6'd5, 1'b1, 1'b0);
        cycle();
        idle();
        check("rd5_set", locks_o, 64'h20);
        cycle();
        cycle();
        check("rd5_held", locks_o, 64'h20);
        check("rd5_busy", 64'(busy_o), 64'h1);
        wb(6'd5);
        cycle();
        idle();
        check("rd5_release", locks_o, 64'h0);
        check("rd5_idle", 64'(busy_o), 64'h0);

        // Register 0 is ignored both ways, with no error.
        launch(6'd0, 1'b1, 1'b0);
        cycle();
        idle();
        wb(6'd0);
        cycle();
        idle();
        check("x0_locks", locks_o, 64'h0);
        check("x0_flags", {62'h0, overflow_o, underflow_o}, 64'h0);

        // Handshake without ready does not launch.
        launch_valid_i = 1'b1;
        launch_rd_i    = 6'd6;
        launch_we_i    = 1'b1;
        cycle();
        idle();
        check("no_ready", locks_o, 64'h0);

        // Saturate rd 7, then overflow on the fourth launch.
        launch(6'd7, 1'b1, 1'b0);
        repeat (3) cycle();
        check("rd7_sat_no_ovf", 64'(overflow_o), 64'h0);
        cycle();
        idle();
        check("rd7_ovf", 64'(overflow_o), 64'h1);
        check("rd7_locked", locks_o, 64'h80);
        // Same-register launch+writeback at max: unchanged, no new effect.
        launch(6'd7, 1'b1, 1'b0);
        wb(6'd7);
        cycle();
        idle();
        wb(6'd7);
        cycle();
        cycle();
        check("rd7_one_left", locks_o, 64'h80);
        cycle();
        idle();
        check("rd7_drained", locks_o, 64'h0);

        // Same-cycle launch+writeback of rd 9 at zero: no change, no error.
        launch(6'd9, 1'b1, 1'b0);
        wb(6'd9);
        cycle();
        idle();
        check("rd9_same_locks", locks_o, 64'h0);
        check("rd9_same_unf", 64'(underflow_o), 64'h0);
        wb(6'd9);
        cycle();
        idle();
        check("rd9_unf", 64'(underflow_o), 64'h1);
        check("rd9_locks", locks_o, 64'h0);

        // Different registers in one cycle both apply.
        launch(6'd11, 1'b1, 1'b0);
        cycle();
        launch(6'd12, 1'b1, 1'b0);
        wb(6'd11);
        cycle();
        idle();
        check("diff_regs", locks_o, 64'h1000);

        // Jump locks everything; done+new jump keeps it; done alone drops it.
        launch(6'd0, 1'b0, 1'b1);
        cycle();
        idle();
        check("jump_set", locks_o, 64'hFFFF_FFFF_FFFF_FFFF);
        launch(6'd0, 1'b0, 1'b1);
        jump_done_i = 1'b1;
        cycle();
        idle();
        check("jump_rearm", locks_o, 64'hFFFF_FFFF_FFFF_FFFF);
        jump_done_i = 1'b1;
        cycle();
        idle();
        check("jump_done", locks_o, 64'h1000);
        jump_done_i = 1'b1;
        cycle();
        idle();
        check("jump_done_idle", locks_o, 64'h1000);

        // Clear overrides a same-cycle launch; sticky flags survive.
        launch(6'd3, 1'b1, 1'b0);
        cycle();
        idle();
        check("pre_clear", locks_o, 64'h1008);
        clear_i = 1'b1;
        launch(6'd20, 1'b1, 1'b0);
        cycle();
        idle();
        check("clear_locks", locks_o, 64'h0);
        check("clear_flags", {62'h0, overflow_o, underflow_o}, 64'h3);

        // Asynchronous reset mid-cycle drops everything at once.
        launch(6'd30, 1'b1, 1'b0);
        cycle();
        idle();
        check("pre_reset", locks_o, 64'h4000_0000);
        #2;
        arst_i = 1'b1;
        model_reset();
        #1;
        check("async_locks", locks_o, 64'h0);
        check("async_busy", 64'(busy_o), 64'h0);
        check("async_flags", {62'h0, overflow_o, underflow_o}, 64'h0);
        cycle();
        arst_i = 1'b0;
        cycle();
        cycle();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv64g_reg_lock_tracker.md
Name: rv64g_reg_lock_tracker

Overview:
Maintains the per-register lock vector consumed by the instruction launcher. A lock is set when the launcher hands off an instruction that writes a destination register. It is released when that register's writeback completes. Jumps lock the whole register file until the jump resolves. The block sits between the launcher output handshake and the writeback port of the register file, and drives the launcher's locks input.

Parameters:
NR, 64, number of architectural registers (32 integer + 32 FP); index 0 is x0.
RW, $clog2(NR), register index width.
CNT_W, 2, width of the per-register outstanding-write counter.
WD_CYCLES, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
clk_i  in  1  clock
arst_i  in  1  asynchronous reset, active-high
clear_i  in  1  synchronous flush of all lock state
launch_valid_i  in  1  launcher output valid (observed)
launch_ready_i  in  1  launcher output ready (observed); launch fires when valid & ready
launch_rd_i  in  RW  destination register of the launched instruction
launch_we_i  in  1  launched instruction writes rd
launch_jump_i  in  1  launched instruction is a jump/branch
jump_done_i  in  1  jump resolved pulse
wb_valid_i  in  1  writeback completes this cycle
wb_rd_i  in  RW  writeback register index
locks_o  out  NR  lock vector to launcher
busy_o  out  1  any bit of locks_o set
overflow_o  out  1  sticky: launch to a register whose counter is saturated
underflow_o  out  1  sticky: writeback to a register whose counter is zero

Behaviour:
- State: cnt[r] (CNT_W bits) for r = 1..NR-1; jump_pend flag; two sticky error flags. cnt[0] does not exist.
- Launch event L = launch_valid_i & launch_ready_i. Writeback event W = wb_valid_i.
- Increment: L & launch_we_i & launch_rd_i != 0 -> cnt[rd]++.
- Saturation: if cnt[rd] is already 2^CNT_W-1, the increment is dropped and overflow_o is set.
- Decrement: W & wb_rd_i != 0 -> cnt[wb_rd]--.
- Zero counter: if cnt[wb_rd] is 0, the decrement is dropped and underflow_o is set.
- Register index 0: launches and writebacks to rd 0 are ignored and never flag an error.
- Same register, same cycle, launch and writeback: counter unchanged, no error, even if it is at max or at 0.
- Different registers, same cycle: both updates apply independently.
- Jump: L & launch_jump_i -> jump_pend = 1 at next edge. jump_done_i clears it.
- Jump set and done in the same cycle: jump_pend = 1 (the new jump wins).
- jump_done_i with jump_pend already 0: ignored, no error.
- locks_o[r] = (cnt[r] != 0) | jump_pend for r >= 1; locks_o[0] = jump_pend.
- locks_o is decoded from registered state only; there is no combinational path from any input to locks_o.
- Latency: an event at edge N is visible on locks_o in cycle N+1, for both set and release.
- busy_o = |locks_o.
- clear_i: at next edge all cnt = 0 and jump_pend = 0. It overrides same-cycle launch, writeback and jump events. It does NOT clear overflow_o or underflow_o.
- Reset (arst_i high, asynchronous): all counters 0, jump_pend 0, errors 0. Therefore locks_o = 0 and busy_o = 0 while reset is asserted.
- Reset asserted mid-operation discards all outstanding locks immediately, without waiting for a clock edge.

Optional Feature:
Macro RV64G_LOCK_WATCHDOG_EN.
- Defined:
  - Adds a per-register age counter (width $clog2(WD_CYCLES+1)) that increments each cycle while cnt[r] != 0.
  - The age counter resets to 0 when cnt[r] returns to 0, on clear_i, and on reset.
  - Reaching WD_CYCLES sets sticky output port wd_expired_o (1 bit).
  - Output port wd_reg_o (RW bits) captures the lowest-indexed register that first expired.
  - wd_expired_o and wd_reg_o clear only on reset.
- Undefined: neither port nor the counters exist; behaviour is otherwise identical.

Test Plan:
- Launch rd = 5 with we = 1, then writeback rd = 5 three cycles later -> locks_o[5] = 1 for exactly cycles 1..3 after the launch; busy_o follows; no errors.
- Launch rd = 0 with we = 1, then writeback rd = 0 -> locks_o stays 0 and the error flags stay 0.
- Launch rd = 7 three times (CNT_W = 2), then a fourth launch -> cnt = 3, overflow_o = 1. Then 3 writebacks -> locks_o[7] = 0.
- Writeback rd = 9 with cnt = 0 -> underflow_o = 1 and locks_o unchanged. Separately, launch and writeback rd = 9 in the same cycle -> no change, no error.
- Launch a jump -> locks_o = all ones next cycle. Then jump_done_i together with a new jump launch -> still all ones. Then jump_done_i alone -> only counter-held locks remain.
- With locks on rd = 3 and rd = 12, pulse clear_i together with a launch of rd = 20 -> locks_o = 0 next cycle and the error flags are retained. Assert arst_i mid-run -> all outputs 0 immediately.
